// File: rtl/mips_muldiv_pkg.sv
// rtl/mips_muldiv_pkg.sv - op encodings, FSM states and sizing helper for the mul/div unit
package mips_muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } muldivState_t;

    // Counter must hold WIDTH/UNROLL itself, not just WIDTH/UNROLL-1
    function automatic int counterWidth(input int width, input int unroll);
        return $clog2(width / unroll + 1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational radix-2 multiply or restoring-divide step
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               mulMode,
    input  logic [2*WIDTH-1:0] accIn,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] accOut
);

    logic [WIDTH:0] addSum;
    logic [WIDTH:0] shiftedRem;
    logic [WIDTH:0] trialDiff;

    // Multiply: {partial product, multiplier} shifts right with the carry kept in the top bit.
    // Divide: {remainder, dividend/quotient} shifts left; a clear borrow bit means the trial fit.
    always_comb begin
        addSum     = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, operand} : '0);
        shiftedRem = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
        trialDiff  = shiftedRem - {1'b0, operand};
        if (mulMode) begin
            accOut = {addSum, accIn[WIDTH-1:1]};
        end else if (!trialDiff[WIDTH]) begin
            accOut = {trialDiff[WIDTH-1:0], accIn[WIDTH-2:0], 1'b1};
        end else begin
            accOut = {shiftedRem[WIDTH-1:0], accIn[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W      = counterWidth(WIDTH, UNROLL);
    localparam logic [CNT_W-1:0] ITERATIONS = CNT_W'(WIDTH / UNROLL);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    muldivState_t       state;
    logic [CNT_W-1:0]   iterCount;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   dividendRaw;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic               isDiv;
    logic               negResult;
    logic               negRemainder;
    logic               divByZero;
    logic               busyReg;
    logic               doneReg;

    logic               isMulDiv;
    logic               isSigned;
    logic               opIsDiv;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;

    // Decode the issued op and reduce signed operands to magnitudes plus sign flags
    always_comb begin
        isMulDiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        isSigned = (op == OP_MULT) || (op == OP_DIV);
        opIsDiv  = (op == OP_DIV) || (op == OP_DIVU);
        aNeg     = isSigned && a[WIDTH-1];
        bNeg     = isSigned && b[WIDTH-1];
        aMag     = aNeg ? -a : a;
        bMag     = bNeg ? -b : b;
    end

    logic [2*WIDTH-1:0] stepAcc [UNROLL+1];

    assign stepAcc[0] = acc;

    for (genvar i = 0; i < UNROLL; i++) begin : gStep
        muldiv_step #(
            .WIDTH   (WIDTH)
        ) uStep (
            .mulMode (!isDiv),
            .accIn   (stepAcc[i]),
            .operand (operand),
            .accOut  (stepAcc[i+1])
        );
    end

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    // Sign-correct the unsigned result; divide by zero bypasses the datapath entirely
    always_comb begin
        product   = negResult ? -acc : acc;
        quotient  = negResult ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remainder = negRemainder ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fixHi     = product[2*WIDTH-1:WIDTH];
        fixLo     = product[WIDTH-1:0];
        if (isDiv) begin
            if (divByZero) begin
                fixHi = dividendRaw;
                fixLo = '1;
            end else begin
                fixHi = remainder;
                fixLo = quotient;
            end
        end
    end

    // Control FSM, iteration datapath and HI/LO update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            iterCount    <= '0;
            acc          <= '0;
            operand      <= '0;
            dividendRaw  <= '0;
            hiReg        <= '0;
            loReg        <= '0;
            isDiv        <= 1'b0;
            negResult    <= 1'b0;
            negRemainder <= 1'b0;
            divByZero    <= 1'b0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        if (op == OP_MTHI) begin
                            hiReg <= a;
                        end else if (op == OP_MTLO) begin
                            loReg <= a;
                        end else if (isMulDiv) begin
                            state        <= RUN;
                            busyReg      <= 1'b1;
                            iterCount    <= ITERATIONS;
                            isDiv        <= opIsDiv;
                            negResult    <= aNeg ^ bNeg;
                            negRemainder <= aNeg;
                            divByZero    <= (b == '0);
                            dividendRaw  <= a;
                            if (opIsDiv) begin
                                acc     <= {{WIDTH{1'b0}}, aMag};
                                operand <= bMag;
                            end else begin
                                acc     <= {{WIDTH{1'b0}}, bMag};
                                operand <= aMag;
                            end
                        end
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                    end else begin
                        acc       <= stepAcc[UNROLL];
                        iterCount <= iterCount - CNT_ONE;
                        if (iterCount == CNT_ONE) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                    if (!cancel) begin
                        hiReg   <= fixHi;
                        loReg   <= fixLo;
                        doneReg <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busyReg;
    assign done = doneReg;
    assign hi   = hiReg;
    assign lo   = loReg;

endmodule
